// File: rtl/load_store_unit.sv
// load_store_unit: data-memory load/store initiator with sign/zero extension of load data.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake from execute
//   req_we/width/unsigned/addr/wdata  request fields (width 0..3 = byte/half/word/double)
//   resp_valid/resp_ready             response handshake to writeback
//   resp_rdata/resp_err               extended load data, illegal-width flag
//   mem_re/we/width/addr/wdata        data-memory controls
//   mem_rdata                         data-memory read data (zero-extended by the memory)
module load_store_unit #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_width,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        width_q, width_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              sign;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] loaded;

    // Only legal widths (0..3) ever reach the extension path.
    always_comb begin
        sign = !uns_q & (width_q == 3'd0 ? mem_rdata[7] :
                         width_q == 3'd1 ? mem_rdata[15] : mem_rdata[31]);
        ext = width_q == 3'd0 ? {{(DATA_W-8){sign}},  mem_rdata[7:0]}  :
              width_q == 3'd1 ? {{(DATA_W-16){sign}}, mem_rdata[15:0]} :
              width_q == 3'd2 ? {{(DATA_W-32){sign}}, mem_rdata[31:0]} : mem_rdata;
        loaded = we_q ? '0 : ext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        width_d = width_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    width_d = req_width;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_width > 3'd3;
                    state_d = req_width > 3'd3 ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (MEM_LAT == 0) begin
                    rdata_d = loaded;
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'(MEM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Data is valid in the cycle the counter shows 1.
                if (cnt_q == 3'd1) begin
                    rdata_d = loaded;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            width_q <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            width_q <= width_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = state_q == IDLE && !rst;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = state_q == RESP ? rdata_q : '0;
    assign resp_err   = state_q == RESP && err_q;
    // Read enable spans ACCESS and WAIT so the address stays presented for the whole latency.
    assign mem_re     = (state_q == ACCESS || state_q == WAIT) && !we_q;
    // Gated by rst so a store caught by a reset edge never writes.
    assign mem_we     = state_q == ACCESS && we_q && !rst;
    assign mem_width  = width_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized checks of load_store_unit at MEM_LAT 0 and 3.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_width = 3'd0;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_ready = 1'b0;

    logic        rr [2];
    logic        rv [2];
    logic        er [2];
    logic        re [2];
    logic        we [2];
    logic [63:0] rd [2];
    logic [2:0]  mw [2];
    logic [4:0]  ma [2];
    logic [63:0] wd [2];
    logic [63:0] mrd [2];

    int errors = 0;
    int checks = 0;
    logic [63:0] refm [2][32];

    always #5 clk = ~clk;

    function automatic logic [63:0] mask(input logic [2:0] w);
        return w == 3'd3 ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 << w)) - 64'd1;
    endfunction

    function automatic logic [63:0] ext(input logic [63:0] v, input logic [2:0] w, input logic u);
        logic [63:0] m;
        logic neg;
        m = mask(w);
        neg = !u && w != 3'd3 && v[(8 << w) - 1];
        return (v & m) | (neg ? ~m : 64'd0);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        logic [63:0] mem [32];
        int re_cnt = 0;
        initial for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        load_store_unit #(.DATA_W(64), .ADDR_W(5), .MEM_LAT(g * 3)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid && sel == 1'(g)), .req_ready(rr[g]),
            .req_we(req_we), .req_width(req_width), .req_unsigned(req_unsigned),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(rv[g]), .resp_ready(resp_ready),
            .resp_rdata(rd[g]), .resp_err(er[g]),
            .mem_re(re[g]), .mem_we(we[g]), .mem_width(mw[g]),
            .mem_addr(ma[g]), .mem_wdata(wd[g]), .mem_rdata(mrd[g])
        );
        always @(posedge clk) begin
            if (we[g]) mem[ma[g]] <= wd[g] & mask(mw[g]);
            re_cnt <= re[g] ? re_cnt + 1 : 0;
        end
        // Memory with read latency: garbage until mem_re has been high long enough.
        assign mrd[g] = re_cnt >= g * 3 ? mem[ma[g]] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    logic        o_rr, o_rv, o_er, o_re, o_we;
    logic [63:0] o_rd, o_wd;
    logic [2:0]  o_mw;
    logic [4:0]  o_ma;
    assign o_rr = sel ? rr[1] : rr[0];
    assign o_rv = sel ? rv[1] : rv[0];
    assign o_er = sel ? er[1] : er[0];
    assign o_re = sel ? re[1] : re[0];
    assign o_we = sel ? we[1] : we[0];
    assign o_rd = sel ? rd[1] : rd[0];
    assign o_wd = sel ? wd[1] : wd[0];
    assign o_mw = sel ? mw[1] : mw[0];
    assign o_ma = sel ? ma[1] : ma[0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat%0d): got %h expected %h", nm, sel ? 3 : 0, act, exp);
        end
    endtask

    task automatic txn(input logic t_we, input logic [2:0] w, input logic un, input logic [4:0] a,
                       input logic [63:0] d, input int hold, output logic [63:0] rdo,
                       output logic ero, output int lat, output int nre, output int nwe,
                       output int bad);
        logic [4:0] a0;
        a0 = 5'd0;
        @(negedge clk);
        chk("req_ready_idle", 64'(o_rr), 64'd1);
        req_valid = 1'b1;
        req_we = t_we;
        req_width = w;
        req_unsigned = un;
        req_addr = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        nre = 0;
        nwe = 0;
        bad = 0;
        while (!o_rv && lat < 30) begin
            if (o_re) begin
                if (nre == 0) a0 = o_ma;
                else if (o_ma !== a0) bad++;
                if (o_ma !== a || o_mw !== w) bad++;
                nre++;
            end
            if (o_we) begin
                if (o_ma !== a || o_mw !== w || o_wd !== d) bad++;
                nwe++;
            end
            if (o_rr) bad++;
            @(negedge clk);
            lat++;
        end
        rdo = o_rd;
        ero = o_er;
        for (int i = 0; i < hold; i++) begin
            if (!o_rv || o_rd !== rdo || o_er !== ero || o_rr || o_re || o_we) bad++;
            @(negedge clk);
        end
        if (o_re || o_we || o_rr) bad++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (o_rv) bad++;
    endtask

    task automatic run(input logic t_we, input logic [2:0] w, input logic un, input logic [4:0] a,
                       input logic [63:0] d, input int hold, input logic [63:0] exp_rd,
                       input logic exp_err);
        logic [63:0] rdo;
        logic ero;
        int lat, nre, nwe, bad, mlat;
        mlat = sel ? 3 : 0;
        txn(t_we, w, un, a, d, hold, rdo, ero, lat, nre, nwe, bad);
        chk("resp_rdata", rdo, exp_rd);
        chk("resp_err", 64'(ero), 64'(exp_err));
        chk("latency", 64'(lat), exp_err ? 64'd1 : 64'(2 + mlat));
        chk("mem_re_cycles", 64'(nre), (exp_err || t_we) ? 64'd0 : 64'(1 + mlat));
        chk("mem_we_cycles", 64'(nwe), (!exp_err && t_we) ? 64'd1 : 64'd0);
        chk("protocol", 64'(bad), 64'd0);
        if (!exp_err && t_we) refm[sel][a] = d & mask(w);
    endtask

    typedef struct {
        logic        s;
        logic        we;
        logic [2:0]  w;
        logic        u;
        logic [4:0]  a;
        logic [63:0] d;
        int          hold;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic reset_outputs(input string nm);
        chk({nm, "_req_ready"}, 64'(o_rr), 64'd0);
        chk({nm, "_resp_valid"}, 64'(o_rv), 64'd0);
        chk({nm, "_resp_rdata"}, o_rd, 64'd0);
        chk({nm, "_resp_err"}, 64'(o_er), 64'd0);
        chk({nm, "_mem_re"}, 64'(o_re), 64'd0);
        chk({nm, "_mem_we"}, 64'(o_we), 64'd0);
        chk({nm, "_mem_width"}, 64'(o_mw), 64'd0);
        chk({nm, "_mem_addr"}, 64'(o_ma), 64'd0);
        chk({nm, "_mem_wdata"}, o_wd, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        r_we, r_u, r_err;
        logic [2:0]  r_w;
        logic [4:0]  r_a;
        logic [63:0] r_d;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) refm[s][i] = 64'd0;
        tbl[0]  = '{1'b0, 1'b1, 3'd3, 1'b0, 5'd5, 64'h1122_3344_5566_7788, 0, 64'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd3, 1'b0, 5'd5, 64'd0, 0, 64'h1122_3344_5566_7788, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 5'd1, 64'h1280, 0, 64'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 5'd1, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 5'd1, 64'd0, 0, 64'h80, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd1, 1'b0, 5'd3, 64'hABCD_8001, 0, 64'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 3'd1, 1'b0, 5'd3, 64'd0, 4, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 3'd5, 1'b0, 5'd5, 64'd0, 0, 64'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 3'd2, 1'b1, 5'd5, 64'd0, 0, 64'h5566_7788, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd2, 1'b0, 5'd9, 64'hDEAD_BEEF, 0, 64'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd2, 1'b0, 5'd9, 64'd0, 2, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd7, 1'b0, 5'd9, 64'h1234, 0, 64'd0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd3, 1'b0, 5'd9, 64'd0, 0, 64'h0000_0000_DEAD_BEEF, 1'b0};

        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1 reset_outputs("reset0");
        sel = 1'b1;
        #1 reset_outputs("reset3");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("req_ready_after_reset", 64'(o_rr), 64'd1);

        for (int i = 0; i < 13; i++) begin
            sel = tbl[i].s;
            run(tbl[i].we, tbl[i].w, tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].hold,
                tbl[i].exp_rd, tbl[i].exp_err);
        end

        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_width = 3'd3;
        req_addr = 5'd2;
        req_wdata = 64'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("store_access_we", 64'(o_we), 64'd1);
        rst = 1'b1;
        #1 chk("store_we_gated_by_rst", 64'(o_we), 64'd0);
        @(negedge clk);
        reset_outputs("midrst");
        rst = 1'b0;
        #1 chk("req_ready_after_midrst", 64'(o_rr), 64'd1);
        run(1'b0, 3'd3, 1'b0, 5'd2, 64'd0, 0, 64'd0, 1'b0);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int n = 0; n < 40; n++) begin
                r_we = 1'($urandom_range(0, 1));
                r_u = 1'($urandom_range(0, 1));
                r_w = $urandom_range(0, 5) == 0 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                r_a = 5'($urandom_range(0, 7));
                r_d = {$urandom, $urandom};
                r_err = r_w > 3'd3;
                run(r_we, r_w, r_u, r_a, r_d, $urandom_range(0, 2),
                    (r_err || r_we) ? 64'd0 : ext(refm[s][r_a], r_w, r_u), r_err);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
